// File: rtl/q8_27_pkg.sv
// rtl/q8_27_pkg.sv - shared Q8.27 constants and divider state type
//
// Word format, symmetric saturation limits and the divider FSM encoding.
// The limits are shared by the library's multiplier and adder.
// No ports.

package q8_27_pkg;

    localparam int Q_W    = 35;
    localparam int Q_FRAC = 27;
    localparam int Q_INT  = 7;

    // Symmetric saturation: the most negative code is never produced.
    localparam logic signed [Q_W-1:0] Q_MAX     = 35'sh3_FFFF_FFFF;
    localparam logic signed [Q_W-1:0] Q_MIN_SYM = -Q_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_DIV,
        S_SGN,
        S_DONE
    } div_state_t;

endpackage

// File: rtl/div_q8_27_seq_if.sv
// rtl/div_q8_27_seq_if.sv - operand and result handshakes of the Q8.27 divider
//
// Groups the operand handshake and the result handshake of the divider.
//   in_valid/in_ready/num/den       : operand pair, master to slave
//   out_valid/out_ready/quot/overload : result, slave to master
// Modports:
//   master : the producer and consumer (bench or surrounding logic)
//   slave  : the divider

interface div_q8_27_seq_if;
    import q8_27_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic signed [Q_W-1:0] num;
    logic signed [Q_W-1:0] den;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [Q_W-1:0] quot;
    logic                  overload;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quot, overload
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quot, overload
    );

endinterface

// File: rtl/q_abs_sign.sv
// rtl/q_abs_sign.sv - sign extraction and unsigned magnitude of a two's complement word
//
// Purely combinational.
// Ports:
//   val : signed input word
//   neg : sign bit of val
//   mag : |val| as an unsigned word of the same width; the most negative
//         code maps exactly to 2^(W-1)

module q_abs_sign #(
    parameter int W = 35
) (
    input  logic signed [W-1:0] val,
    output logic                neg,
    output logic        [W-1:0] mag
);

    assign neg = val[W-1];
    assign mag = neg ? $unsigned(-val) : $unsigned(val);

endmodule

// File: rtl/div_q8_27_seq.sv
// rtl/div_q8_27_seq.sv - sequential signed Q8.27 restoring divider with saturation
//
// Computes num/den in Q8.27, one quotient bit per clock, truncated toward zero.
// Divide-by-zero and out-of-range quotients saturate symmetrically and raise
// overload.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : div_q8_27_seq_if.slave
//         in_valid/in_ready/num/den       : operand pair
//         out_valid/out_ready/quot/overload : result, held until accepted

module div_q8_27_seq
    import q8_27_pkg::*;
#(
    parameter int DATA_W = Q_W,
    parameter int FRAC_W = Q_FRAC
) (
    input  logic           clk,
    input  logic           rst,
    div_q8_27_seq_if.slave bus
);

    localparam int         INT_W = DATA_W - 1 - FRAC_W;
    localparam int         QB    = DATA_W - 1;     // quotient magnitude bits
    localparam logic [5:0] LAST  = 6'(QB - 1);

    div_state_t state, state_nxt;

    logic              num_neg_in, den_neg_in;
    logic [DATA_W-1:0] num_mag_in, den_mag_in;

    q_abs_sign #(.W(DATA_W)) u_abs_num (.val(bus.num), .neg(num_neg_in), .mag(num_mag_in));
    q_abs_sign #(.W(DATA_W)) u_abs_den (.val(bus.den), .neg(den_neg_in), .mag(den_mag_in));

    logic                     sign, num_neg;
    logic        [DATA_W-1:0] num_mag, den_mag;
    logic        [DATA_W:0]   rem;        // one spare bit keeps trial overflow-free
    logic        [QB-1:0]     shreg;      // low dividend bits still to be shifted in
    logic        [QB-1:0]     q;
    logic        [5:0]        cnt;
    logic signed [DATA_W-1:0] quot_r;
    logic                     ovl_r;

    logic                     div_zero, ovf;
    logic        [DATA_W+1:0] trial;
    logic        [DATA_W:0]   rem_nxt;

    assign div_zero = (den_mag == '0);
    // Quotient magnitude reaches 2^34 exactly when |num| >= |den|*2^INT_W.
    assign ovf      = ({{INT_W{1'b0}}, num_mag} >= {den_mag, {INT_W{1'b0}}});

    // A borrow out of the top bit means the trial subtraction went negative.
    assign trial    = {rem, shreg[QB-1]} - {2'b00, den_mag};
    assign rem_nxt  = trial[DATA_W+1] ? {rem[DATA_W-1:0], shreg[QB-1]} : trial[DATA_W:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.in_valid) state_nxt = S_CHK;
            S_CHK:   state_nxt = (div_zero || ovf) ? S_DONE : S_DIV;
            S_DIV:   if (cnt == LAST) state_nxt = S_SGN;
            S_SGN:   state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign    <= 1'b0;
            num_neg <= 1'b0;
            num_mag <= '0;
            den_mag <= '0;
            rem     <= '0;
            shreg   <= '0;
            q       <= '0;
            cnt     <= '0;
            quot_r  <= '0;
            ovl_r   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        sign    <= num_neg_in ^ den_neg_in;
                        num_neg <= num_neg_in;
                        num_mag <= num_mag_in;
                        den_mag <= den_mag_in;
                    end
                end
                S_CHK: begin
                    if (div_zero) begin
                        ovl_r  <= 1'b1;
                        quot_r <= (num_mag == '0) ? '0 : (num_neg ? Q_MIN_SYM : Q_MAX);
                    end else if (ovf) begin
                        ovl_r  <= 1'b1;
                        quot_r <= sign ? Q_MIN_SYM : Q_MAX;
                    end else begin
                        // Dividend is |num|*2^FRAC_W; its top bits seed the
                        // remainder, the rest stream in one per cycle.
                        rem   <= {{(INT_W+1){1'b0}}, num_mag[DATA_W-1:INT_W]};
                        shreg <= {num_mag[INT_W-1:0], {FRAC_W{1'b0}}};
                        cnt   <= '0;
                    end
                end
                S_DIV: begin
                    rem   <= rem_nxt;
                    shreg <= {shreg[QB-2:0], 1'b0};
                    q     <= {q[QB-2:0], ~trial[DATA_W+1]};
                    cnt   <= cnt + 6'd1;
                end
                S_SGN: begin
                    quot_r <= sign ? -$signed({1'b0, q}) : $signed({1'b0, q});
                    ovl_r  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.quot      = quot_r;
    assign bus.overload  = ovl_r;

endmodule
